// File: rtl/raster_pkg.sv
// Shared types and constants for the triangle edge rasterizer.
// Holds the FSM state encoding, bitmap size, coordinate and edge-index types.
package raster_pkg;

    localparam int unsigned BITMAP_DIM = 64;

    typedef logic [7:0] coord_t;
    typedef logic [1:0] edge_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EDGE_INIT,
        EDGE_STEP,
        FINISH
    } state_t;

    localparam edge_idx_t LAST_EDGE = 2'd2;

    function automatic coord_t min3(coord_t a, coord_t b, coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic coord_t max3(coord_t a, coord_t b, coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/edge_stepper.sv
// Bresenham line walker: load latches both endpoints and the error terms,
// each step strobe advances the current point by one pixel toward the end.
module edge_stepper #(
    parameter int unsigned PW = 6
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          load,
    input  logic          step,
    input  logic [PW-1:0] xa,
    input  logic [PW-1:0] ya,
    input  logic [PW-1:0] xb,
    input  logic [PW-1:0] yb,
    output logic [PW-1:0] cur_x,
    output logic [PW-1:0] cur_y,
    output logic          is_last
);

    localparam int unsigned EW = PW + 2;
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0] x_q, x_d, y_q, y_d, xe_q, xe_d, ye_q, ye_d;
    logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic [PW-1:0] adx, ady;
    logic signed [EW:0] e2, dx_ext, dy_ext;

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        xe_d     = xe_q;
        ye_d     = ye_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        adx      = (xb >= xa) ? (xb - xa) : (xa - xb);
        ady      = (yb >= ya) ? (yb - ya) : (ya - yb);
        // Both comparisons use the pre-update error, one bit wider to avoid overflow.
        e2       = {err_q, 1'b0};
        dx_ext   = {dx_q[EW-1], dx_q};
        dy_ext   = {dy_q[EW-1], dy_q};

        if (load) begin
            x_d      = xa;
            y_d      = ya;
            xe_d     = xb;
            ye_d     = yb;
            dx_d     = {2'b00, adx};
            dy_d     = '0 - {2'b00, ady};
            err_d    = {2'b00, adx} - {2'b00, ady};
            sx_neg_d = (xb < xa);
            sy_neg_d = (yb < ya);
        end else if (step && !is_last) begin
            if (e2 >= dy_ext) begin
                err_d = err_d + dy_q;
                x_d   = sx_neg_q ? (x_q - ONE) : (x_q + ONE);
            end
            if (e2 <= dx_ext) begin
                err_d = err_d + dx_q;
                y_d   = sy_neg_q ? (y_q - ONE) : (y_q + ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_q      <= '0;
            y_q      <= '0;
            xe_q     <= '0;
            ye_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            xe_q     <= xe_d;
            ye_q     <= ye_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end

    assign cur_x   = x_q;
    assign cur_y   = y_q;
    assign is_last = (x_q == xe_q) && (y_q == ye_q);

endmodule

// File: rtl/edge_raster.sv
// Triangle outline rasterizer: bounds the triangle, then walks its three
// edges with a Bresenham stepper, setting one bitmap pixel per cycle.
module edge_raster
    import raster_pkg::*;
#(
    parameter int unsigned BITMAP_DIM = raster_pkg::BITMAP_DIM
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             start,
    input  logic [47:0]                      coordinates,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [7:0]                       origin_x,
    output logic [7:0]                       origin_y,
    output logic [BITMAP_DIM*BITMAP_DIM-1:0] line_buffer
);

    localparam int unsigned PW = $clog2(BITMAP_DIM);
    localparam coord_t MAX_SPAN = coord_t'(BITMAP_DIM - 1);

    state_t    state_q, state_d;
    logic [47:0] coord_q, coord_d;
    coord_t    origin_x_q, origin_x_d, origin_y_q, origin_y_d;
    logic      error_q, error_d;
    edge_idx_t edge_q, edge_d;
    logic [BITMAP_DIM*BITMAP_DIM-1:0] line_buffer_q, line_buffer_d;

    coord_t xmin, xmax, ymin, ymax;
    coord_t ax, ay, bx, by, rel_ax, rel_ay, rel_bx, rel_by;
    logic   stp_load, stp_step, is_last;
    logic [PW-1:0] cur_x, cur_y;

    assign xmin = min3(coord_q[7:0],  coord_q[23:16], coord_q[39:32]);
    assign xmax = max3(coord_q[7:0],  coord_q[23:16], coord_q[39:32]);
    assign ymin = min3(coord_q[15:8], coord_q[31:24], coord_q[47:40]);
    assign ymax = max3(coord_q[15:8], coord_q[31:24], coord_q[47:40]);

    always_comb begin
        case (edge_q)
            2'd1: begin
                ax = coord_q[23:16]; ay = coord_q[31:24];
                bx = coord_q[39:32]; by = coord_q[47:40];
            end
            2'd2: begin
                ax = coord_q[39:32]; ay = coord_q[47:40];
                bx = coord_q[7:0];   by = coord_q[15:8];
            end
            default: begin
                ax = coord_q[7:0];   ay = coord_q[15:8];
                bx = coord_q[23:16]; by = coord_q[31:24];
            end
        endcase
        rel_ax = ax - origin_x_q;
        rel_ay = ay - origin_y_q;
        rel_bx = bx - origin_x_q;
        rel_by = by - origin_y_q;
    end

    edge_stepper #(.PW(PW)) u_stepper (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (stp_load),
        .step    (stp_step),
        .xa      (rel_ax[PW-1:0]),
        .ya      (rel_ay[PW-1:0]),
        .xb      (rel_bx[PW-1:0]),
        .yb      (rel_by[PW-1:0]),
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .is_last (is_last)
    );

    always_comb begin
        state_d       = state_q;
        coord_d       = coord_q;
        origin_x_d    = origin_x_q;
        origin_y_d    = origin_y_q;
        error_d       = error_q;
        edge_d        = edge_q;
        line_buffer_d = line_buffer_q;
        stp_load      = 1'b0;
        stp_step      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    coord_d = coordinates;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                origin_x_d    = xmin;
                origin_y_d    = ymin;
                line_buffer_d = '0;
                edge_d        = '0;
                if ((xmax - xmin) > MAX_SPAN || (ymax - ymin) > MAX_SPAN) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    error_d = 1'b0;
                    state_d = EDGE_INIT;
                end
            end
            EDGE_INIT: begin
                stp_load = 1'b1;
                state_d  = EDGE_STEP;
            end
            EDGE_STEP: begin
                line_buffer_d[{cur_y, cur_x}] = 1'b1;
                if (is_last) begin
                    if (edge_q == LAST_EDGE) begin
                        state_d = FINISH;
                    end else begin
                        edge_d  = edge_q + 2'd1;
                        state_d = EDGE_INIT;
                    end
                end else begin
                    stp_step = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            coord_q       <= '0;
            origin_x_q    <= '0;
            origin_y_q    <= '0;
            error_q       <= 1'b0;
            edge_q        <= '0;
            line_buffer_q <= '0;
        end else begin
            state_q       <= state_d;
            coord_q       <= coord_d;
            origin_x_q    <= origin_x_d;
            origin_y_q    <= origin_y_d;
            error_q       <= error_d;
            edge_q        <= edge_d;
            line_buffer_q <= line_buffer_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FINISH);
    assign error       = error_q;
    assign origin_x    = origin_x_q;
    assign origin_y    = origin_y_q;
    assign line_buffer = line_buffer_q;

endmodule

// File: tb/tb_edge_raster.sv
// Scoreboard bench for edge_raster: a plain-integer Bresenham reference
// predicts bitmap, origin, error and latency for each accepted triangle.
module tb_edge_raster;

    localparam int N  = 64;
    localparam int NB = N * N;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic [47:0]   coordinates = '0;
    logic          busy, done, error;
    logic [7:0]    origin_x, origin_y;
    logic [NB-1:0] line_buffer;

    always #5 clk = ~clk;

    edge_raster #(.BITMAP_DIM(N)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .coordinates (coordinates),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .origin_x    (origin_x),
        .origin_y    (origin_y),
        .line_buffer (line_buffer)
    );

    typedef struct {
        logic [NB-1:0] bm;
        int            ox;
        int            oy;
        int            err;
        int            lat;
        int            start_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_int(string name, int act, int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [47:0] pack(int x0, int y0, int x1, int y1, int x2, int y2);
        return {8'(y2), 8'(x2), 8'(y1), 8'(x1), 8'(y0), 8'(x0)};
    endfunction

    function automatic logic [47:0] rand48();
        return {16'($urandom), $urandom};
    endfunction

    function automatic logic [47:0] rand_tri();
        int bx, by, span;
        bx   = int'($urandom_range(0, 255));
        by   = int'($urandom_range(0, 255));
        span = ($urandom_range(0, 4) == 0) ? 100 : 63;
        return pack(bx + int'($urandom_range(0, span)), by + int'($urandom_range(0, span)),
                    bx + int'($urandom_range(0, span)), by + int'($urandom_range(0, span)),
                    bx + int'($urandom_range(0, span)), by + int'($urandom_range(0, span)));
    endfunction

    function automatic exp_t model(logic [47:0] c);
        exp_t e;
        int x[3], y[3];
        int xmin, xmax, ymin, ymax;
        int xa, ya, xb, yb, adx, ady, sx, sy, er, e2;
        x[0] = int'(c[7:0]);   y[0] = int'(c[15:8]);
        x[1] = int'(c[23:16]); y[1] = int'(c[31:24]);
        x[2] = int'(c[39:32]); y[2] = int'(c[47:40]);
        xmin = x[0]; xmax = x[0]; ymin = y[0]; ymax = y[0];
        for (int i = 1; i < 3; i++) begin
            if (x[i] < xmin) xmin = x[i];
            if (x[i] > xmax) xmax = x[i];
            if (y[i] < ymin) ymin = y[i];
            if (y[i] > ymax) ymax = y[i];
        end
        e.bm = '0;
        e.ox = xmin;
        e.oy = ymin;
        e.start_cyc = 0;
        if (xmax - xmin > N - 1 || ymax - ymin > N - 1) begin
            e.err = 1;
            e.lat = 2;
            return e;
        end
        e.err = 0;
        e.lat = 2;
        for (int k = 0; k < 3; k++) begin
            xa  = x[k] - xmin;           ya = y[k] - ymin;
            xb  = x[(k + 1) % 3] - xmin; yb = y[(k + 1) % 3] - ymin;
            adx = (xb > xa) ? xb - xa : xa - xb;
            ady = (yb > ya) ? yb - ya : ya - yb;
            sx  = (xb >= xa) ? 1 : -1;
            sy  = (yb >= ya) ? 1 : -1;
            er  = adx - ady;
            e.lat += ((adx > ady) ? adx : ady) + 2;
            for (int g = 0; g < 4 * N; g++) begin
                e.bm[ya * N + xa] = 1'b1;
                if (xa == xb && ya == yb) break;
                e2 = 2 * er;
                if (e2 >= -ady) begin er -= ady; xa += sx; end
                if (e2 <= adx)  begin er += adx; ya += sy; end
            end
        end
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        int   first;
        forever begin
            @(negedge clk);
            if (n_rst && done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=done required=no_done origin=(%0d,%0d)",
                             origin_x, origin_y);
                end else begin
                    e = sb.pop_front();
                    check_int("error", int'(error), e.err);
                    check_int("origin_x", int'(origin_x), e.ox);
                    check_int("origin_y", int'(origin_y), e.oy);
                    check_int("latency", cyc - e.start_cyc + 1, e.lat);
                    checks++;
                    if (line_buffer !== e.bm) begin
                        failures++;
                        first = -1;
                        for (int i = 0; i < NB; i++)
                            if (first < 0 && line_buffer[i] !== e.bm[i]) first = i;
                        $display("FAIL bitmap actual_bits=%0d required_bits=%0d first_diff_row=%0d col=%0d",
                                 $countones(line_buffer), $countones(e.bm), first / N, first % N);
                    end
                end
            end
        end
    end

    task automatic issue(logic [47:0] c);
        exp_t e;
        e = model(c);
        @(negedge clk);
        start = 1'b1;
        coordinates = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.start_cyc = cyc;
        sb.push_back(e);
        coordinates = rand48();
        check_int("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !busy) return;
        end
        checks++;
        failures++;
        $display("FAIL timeout_idle actual_pending=%0d required_pending=0", sb.size());
        sb.delete();
    endtask

    task automatic wait_done_neg();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) return;
        end
        checks++;
        failures++;
        $display("FAIL timeout_done actual=no_done required=done");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        check_int("rst_error", int'(error), 0);
        check_int("rst_origin_x", int'(origin_x), 0);
        check_int("rst_line_buffer_bits", $countones(line_buffer), 0);
        @(negedge clk);
        n_rst = 1'b1;

        issue(pack(10, 20, 10, 20, 10, 20));
        wait_idle();
        issue(pack(0, 0, 5, 0, 0, 5));
        wait_idle();
        issue(pack(0, 0, 64, 0, 0, 0));
        wait_idle();
        issue(pack(100, 100, 163, 100, 100, 163));
        wait_idle();

        // A start while busy must neither restart nor be queued.
        issue(pack(2, 60, 50, 3, 30, 40));
        repeat (20) @(negedge clk);
        start = 1'b1;
        coordinates = pack(1, 1, 9, 9, 1, 9);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Start during FINISH is dropped; start in the next cycle is taken.
        issue(pack(5, 5, 20, 9, 11, 30));
        wait_done_neg();
        start = 1'b1;
        coordinates = pack(0, 0, 63, 63, 0, 63);
        @(posedge clk);
        #1;
        issue(pack(40, 41, 42, 50, 60, 45));
        wait_idle();

        issue(pack(10, 12, 70, 12, 10, 72));
        repeat (30) @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check_int("midrst_busy", int'(busy), 0);
        check_int("midrst_done", int'(done), 0);
        check_int("midrst_error", int'(error), 0);
        check_int("midrst_origin_x", int'(origin_x), 0);
        check_int("midrst_origin_y", int'(origin_y), 0);
        check_int("midrst_line_buffer_bits", $countones(line_buffer), 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        issue(pack(3, 3, 3, 3, 3, 3));
        wait_idle();

        repeat (25) begin
            issue(rand_tri());
            wait_idle();
        end

        check_int("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
